mult_acc_stage: RTL

//   Accumulator stage directly downstream of mult16x16: consumes its 32-bit products, sums a frame
//   of up to MAX_TERMS products and presents the wide sum plus the term count through a valid/ready

---
 rtl/mult_acc_stage.sv | 112 +++++++++++
 1 files changed

// File: rtl/mult_acc_stage.sv
//------------------------------------------------------------------------------
// Module      : mult_acc_stage
// Description : Sums frames of unsigned products and presents the sum and term
//               count on a valid/ready output. Optional macro ACC_SATURATE_EN
//               clamps the accumulator on overflow instead of wrapping.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mult_acc_stage #(
   parameter int PROD_W    = 32,
   parameter int ACC_W     = 40,
   parameter int MAX_TERMS = 256,
   localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              acc_clr,
   input  logic              prod_valid,
   input  logic [PROD_W-1:0] prod_data,
   input  logic              prod_last,
   output logic              prod_ready,
   output logic              sum_valid,
   input  logic              sum_ready,
   output logic [ACC_W-1:0]  sum_data,
   output logic [CNT_W-1:0]  sum_count,
   output logic              sum_ovf
);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_accum = 2'd1;
   localparam logic [1:0] c_st_done  = 2'd2;

   localparam logic             c_single  = (MAX_TERMS == 1);
   localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_TERMS);

   logic [1:0]       r_state;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;

   logic             w_accept;
   logic [ACC_W:0]   w_sum;
   logic             w_carry;
   logic [ACC_W-1:0] w_acc_next;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_at_max;

   always_comb begin
      w_accept  = prod_valid & prod_ready;
      w_sum     = {1'b0, r_acc} + (ACC_W+1)'(prod_data);
      w_carry   = w_sum[ACC_W];
      w_cnt_inc = r_cnt + CNT_W'(1);
      w_at_max  = (w_cnt_inc == c_max_cnt);
`ifdef ACC_SATURATE_EN
      // Once clamped every further add carries again (or adds zero), so the
      // clamp holds for the rest of the frame without extra state.
      w_acc_next = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
      w_acc_next = w_sum[ACC_W-1:0];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst || acc_clr) begin
         r_state <= c_st_idle;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (w_accept) begin
                  r_acc   <= ACC_W'(prod_data);
                  r_cnt   <= CNT_W'(1);
                  r_ovf   <= 1'b0;
                  r_state <= (prod_last || c_single) ? c_st_done : c_st_accum;
               end
            end
            c_st_accum: begin
               if (w_accept) begin
                  r_acc   <= w_acc_next;
                  r_cnt   <= w_cnt_inc;
                  r_ovf   <= r_ovf | w_carry;
                  r_state <= (prod_last || w_at_max) ? c_st_done : c_st_accum;
               end
            end
            c_st_done: begin
               if (sum_ready) begin
                  r_state <= c_st_idle;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_ovf   <= 1'b0;
               end
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   // No skid buffer: input stalls for as long as a finished sum is held.
   always_comb begin
      prod_ready = ~rst & (r_state != c_st_done);
      sum_valid  = (r_state == c_st_done);
      sum_data   = sum_valid ? r_acc : '0;
      sum_count  = sum_valid ? r_cnt : '0;
      sum_ovf    = sum_valid & r_ovf;
   end

endmodule

`default_nettype wire
